// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Burst support in the arbiter is compiled in with FIFO_ARB_BURST_EN.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // Rotation pointer / owner index width (PTR_W) for a given producer count.
  function automatic int ptr_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // Burst counter width (CNT_W) able to hold the value MAX_BURST.
  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational rotating priority encoder: first requester at or above ptr,
// wrapping from N_REQ-1 back to 0.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] idx,
  output logic [N_REQ-1:0] sel
);

  logic             any_s;
  logic [PTR_W-1:0] idx_s;
  logic [PTR_W:0]   sum_v;
  logic [PTR_W-1:0] cand_v;

  // Scan from ptr upward; ptr < N_REQ, so a single subtraction wraps the sum.
  always_comb begin
    any_s  = 1'b0;
    idx_s  = {PTR_W{1'b0}};
    sum_v  = {(PTR_W+1){1'b0}};
    cand_v = {PTR_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      sum_v  = {1'b0, ptr} + (PTR_W+1)'(k);
      cand_v = (sum_v >= (PTR_W+1)'(N_REQ)) ? PTR_W'(sum_v - (PTR_W+1)'(N_REQ))
                                            : PTR_W'(sum_v);
      idx_s  = (!any_s && req[cand_v]) ? cand_v : idx_s;
      any_s  = any_s | req[cand_v];
    end
  end

  // One-hot view of the winner.
  always_comb begin
    sel = {N_REQ{1'b0}};
    for (int j = 0; j < N_REQ; j++) begin
      sel[j] = any_s && (idx_s == PTR_W'(j));
    end
  end

  assign any = any_s;
  assign idx = idx_s;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// Define FIFO_ARB_BURST_EN to lock the port to one owner for up to MAX_BURST words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    write,
  output logic [DATA_W-1:0]       in,
  input  logic                    full
);

  localparam int PTR_W = ptr_w(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255 || DATA_W < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: parameter out of range");
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_REQ - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  logic             pick_any_s;
  logic [PTR_W-1:0] pick_idx_s;
  logic [N_REQ-1:0] pick_sel_s;
  logic [N_REQ-1:0] gnt_s;
  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] ptr_nxt_s;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req (req),
    .ptr (ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s),
    .sel (pick_sel_s)
  );

`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_W = cnt_w(MAX_BURST);

  arb_state_t       state_r;
  arb_state_t       state_nxt_s;
  logic [PTR_W-1:0] owner_r;
  logic [PTR_W-1:0] owner_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Grant selection and next-state logic for the idle/lock FSM.
  always_comb begin
    gnt_s       = {N_REQ{1'b0}};
    ptr_nxt_s   = ptr_r;
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_any_s && !full) begin
          gnt_s = pick_sel_s;
          if (MAX_BURST > 1) begin
            state_nxt_s = ARB_LOCK;
            owner_nxt_s = pick_idx_s;
            cnt_nxt_s   = CNT_W'(1);
          end else begin
            ptr_nxt_s = ptr_inc(pick_idx_s);
          end
        end else begin
          gnt_s = {N_REQ{1'b0}};
        end
      end
      ARB_LOCK: begin
        // A dropped owner request releases the lock even while full.
        if (!req[owner_r]) begin
          state_nxt_s = ARB_IDLE;
          ptr_nxt_s   = ptr_inc(owner_r);
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (!full) begin
          gnt_s[owner_r] = 1'b1;
          if ((cnt_r + CNT_W'(1)) == CNT_W'(MAX_BURST)) begin
            state_nxt_s = ARB_IDLE;
            ptr_nxt_s   = ptr_inc(owner_r);
            cnt_nxt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Pointer, FSM state, owner and burst count registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_r   <= {PTR_W{1'b0}};
      state_r <= ARB_IDLE;
      owner_r <= {PTR_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      ptr_r   <= ptr_nxt_s;
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end
`else
  // Single-word round robin: grant the winner and move past it.
  always_comb begin
    gnt_s     = {N_REQ{1'b0}};
    ptr_nxt_s = ptr_r;
    if (pick_any_s && !full) begin
      gnt_s     = pick_sel_s;
      ptr_nxt_s = ptr_inc(pick_idx_s);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Rotation pointer register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_r <= {PTR_W{1'b0}};
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end
`endif

  assign gnt   = rst ? gnt_s : {N_REQ{1'b0}};
  assign write = |gnt;

  // One-hot AND-OR data mux; zero when nothing is granted.
  always_comb begin
    in = {DATA_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      in = in | (data[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}});
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, then random
// traffic into a 10-entry FIFO model checked against a reference arbiter.
module tb_fifo_wr_arbiter;

  localparam int N_REQ     = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int FIFO_SIZE = 10;
`ifdef FIFO_ARB_BURST_EN
  localparam int MB_EFF = MAX_BURST;
`else
  localparam int MB_EFF = 1;
`endif
  localparam int WAIT_BOUND = (N_REQ - 1) * MB_EFF;

  logic                    clk  = 1'b0;
  logic                    rst  = 1'b0;
  logic [N_REQ-1:0]        req  = '0;
  logic [N_REQ*DATA_W-1:0] data = '0;
  logic                    full = 1'b0;
  logic [N_REQ-1:0]        gnt;
  logic                    write;
  logic [DATA_W-1:0]       in;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ     (N_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .data  (data),
    .gnt   (gnt),
    .write (write),
    .in    (in),
    .full  (full)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic             r;
    logic [N_REQ-1:0] rq;
    logic             f;
    logic [N_REQ-1:0] exp_gnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [N_REQ-1:0] rq, input logic f,
                     input logic [N_REQ-1:0] g);
    vec_t v;
    v.r = r; v.rq = rq; v.f = f; v.exp_gnt = g;
    vecs.push_back(v);
  endtask

  function automatic logic [DATA_W-1:0] word_of(input logic [N_REQ-1:0] g,
                                                 input logic [N_REQ*DATA_W-1:0] d);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < N_REQ; i++) if (g[i]) w = d[i*DATA_W +: DATA_W];
    return w;
  endfunction

  // Reference arbiter: ownership tracked as an index (-1 = none) plus a word count.
  int m_ptr = 0;
  int m_owner = -1;
  int m_cnt = 0;

  task automatic model_step(input logic r, input logic [N_REQ-1:0] rq, input logic f,
                            output int g);
    g = -1;
    if (!r) begin
      m_ptr = 0; m_owner = -1; m_cnt = 0;
    end else if (m_owner >= 0) begin
      if (!rq[m_owner]) begin
        m_ptr = (m_owner + 1) % N_REQ; m_owner = -1;
      end else if (!f) begin
        g = m_owner; m_cnt++;
        if (m_cnt == MB_EFF) begin
          m_ptr = (m_owner + 1) % N_REQ; m_owner = -1;
        end
      end
    end else if (!f) begin
      for (int k = 0; k < N_REQ; k++)
        if (g < 0 && rq[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
      if (g >= 0) begin
        if (MB_EFF > 1) begin m_owner = g; m_cnt = 1; end
        else m_ptr = (g + 1) % N_REQ;
      end
    end
  endtask

  logic [DATA_W-1:0] pdata [N_REQ];
  logic              pend  [N_REQ];
  int                wcnt  [N_REQ];
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_q[$];

  initial begin
    logic [N_REQ-1:0] eg;
    logic             rv;
    logic             fv;
    logic [DATA_W-1:0] got;
    int g;

    // Directed vectors, starting from 3 reset cycles with every producer requesting.
    add(1'b0, 4'b1111, 1'b0, 4'b0000);
    add(1'b0, 4'b1111, 1'b0, 4'b0000);
    add(1'b0, 4'b1111, 1'b0, 4'b0000);
`ifdef FIFO_ARB_BURST_EN
    for (int k = 0; k < 4; k++) add(1'b1, 4'b1111, 1'b0, 4'b0001);
    add(1'b1, 4'b1111, 1'b0, 4'b0010);
    add(1'b1, 4'b1111, 1'b1, 4'b0000);
    for (int k = 0; k < 3; k++) add(1'b1, 4'b1111, 1'b0, 4'b0010);
    add(1'b1, 4'b1111, 1'b0, 4'b0100);
    add(1'b1, 4'b1111, 1'b0, 4'b0100);
    add(1'b1, 4'b1001, 1'b0, 4'b0000);
    add(1'b1, 4'b1001, 1'b0, 4'b1000);
    add(1'b0, 4'b1111, 1'b0, 4'b0000);
    add(1'b1, 4'b1111, 1'b0, 4'b0001);
`else
    add(1'b1, 4'b1111, 1'b0, 4'b0001);
    add(1'b1, 4'b1111, 1'b0, 4'b0010);
    add(1'b1, 4'b1111, 1'b0, 4'b0100);
    add(1'b1, 4'b1111, 1'b0, 4'b1000);
    add(1'b1, 4'b1111, 1'b0, 4'b0001);
    for (int k = 0; k < 5; k++) add(1'b1, 4'b1111, 1'b1, 4'b0000);
    add(1'b1, 4'b1111, 1'b0, 4'b0010);
    add(1'b1, 4'b1111, 1'b0, 4'b0100);
    add(1'b1, 4'b1001, 1'b0, 4'b1000);
    add(1'b1, 4'b1001, 1'b0, 4'b0001);
    add(1'b1, 4'b0000, 1'b0, 4'b0000);
    add(1'b1, 4'b0100, 1'b0, 4'b0100);
    add(1'b0, 4'b1111, 1'b0, 4'b0000);
    add(1'b1, 4'b1111, 1'b0, 4'b0001);
`endif

    data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].r; req = vecs[k].rq; full = vecs[k].f;
      #1;
      check($sformatf("vec%0d gnt", k), 32'(gnt), 32'(vecs[k].exp_gnt));
      check($sformatf("vec%0d write", k), 32'(write), 32'(|vecs[k].exp_gnt));
      check($sformatf("vec%0d in", k), 32'(in), 32'(word_of(vecs[k].exp_gnt, data)));
    end

    // Random traffic into a bounded FIFO; producers hold req/data until granted.
    for (int i = 0; i < N_REQ; i++) begin pend[i] = 1'b0; wcnt[i] = 0; pdata[i] = '0; end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (fifo_q.size() > 0 && $urandom_range(0, 1) == 0) begin
        got = fifo_q.pop_front();
        if (exp_q.size() > 0) check("fifo order", 32'(got), 32'(exp_q.pop_front()));
        else check("fifo extra word", 32'(exp_q.size()), 32'(1));
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1; pdata[i] = 8'($urandom); wcnt[i] = 0;
        end
        req[i] = pend[i];
        data[i*DATA_W +: DATA_W] = pdata[i];
      end
      rv = !((c < 2) || ($urandom_range(0, 299) == 0));
      fv = (fifo_q.size() >= FIFO_SIZE);
      rst = rv; full = fv;
      #1;
      model_step(rv, req, fv, g);
      eg = (g >= 0) ? N_REQ'(1 << g) : '0;
      check("rand gnt", 32'(gnt), 32'(eg));
      check("rand write", 32'(write), 32'(g >= 0));
      check("rand in", 32'(in), 32'((g >= 0) ? pdata[g] : 8'h00));
      if (write && !fv) fifo_q.push_back(in);
      if (g >= 0) begin
        exp_q.push_back(pdata[g]);
        check("wait bound", 32'(wcnt[g] <= WAIT_BOUND), 32'(1));
        pend[g] = 1'b0;
        for (int i = 0; i < N_REQ; i++) if (i != g && pend[i]) wcnt[i]++;
      end
      if (!rv) for (int i = 0; i < N_REQ; i++) wcnt[i] = 0;
    end

    // Drain whatever is still queued.
    while (fifo_q.size() > 0) begin
      got = fifo_q.pop_front();
      if (exp_q.size() > 0) check("drain order", 32'(got), 32'(exp_q.pop_front()));
      else check("drain extra word", 32'(exp_q.size()), 32'(1));
    end
    check("drain leftover", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
